// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_pkg
// Purpose  : Shared switch constants: data width, FIFO depth, port addresses.
// Revision : 1.0
// ============================================================================
package switch_pkg;

  localparam int W_WIDTH_DEF    = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam int PORT_ADDR_0 = 0;
  localparam int PORT_ADDR_1 = 1;
  localparam int PORT_ADDR_2 = 2;
  localparam int PORT_ADDR_3 = 3;

  // Smallest width w with 2**w >= value; used for FIFO pointer sizing.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_out_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : port_out_buffer_if
// Purpose  : Write-side (switch FSM) and read-side (port) signals of one queue.
// Revision : 1.0
// ============================================================================
interface port_out_buffer_if #(
  parameter int W_WIDTH = 8
) ();

  logic               wr_en;
  logic [W_WIDTH-1:0] port_addr;
  logic [W_WIDTH-1:0] data_in;
  logic               port_busy;
  logic               port_ready;
  logic               port_read;
  logic [W_WIDTH-1:0] port_data;

  modport master (
    output wr_en, port_addr, data_in, port_read,
    input  port_busy, port_ready, port_data
  );

  modport slave (
    input  wr_en, port_addr, data_in, port_read,
    output port_busy, port_ready, port_data
  );

endinterface
`default_nettype wire

// File: rtl/port_out_buffer_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_ctrl
// Purpose  : FIFO write/read pointers and occupancy count with accept strobes.
// Revision : 1.0
// ============================================================================
module fifo_ptr_ctrl
  import switch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             wr_req,
  input  wire logic             rd_req,
  output logic                  wr_accept,
  output logic                  rd_accept,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic [PTR_W-1:0]      rd_ptr
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Acceptance uses the pre-edge count, so a full FIFO only takes the read.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    wr_accept = wr_req && !full;
    rd_accept = rd_req && !empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

endmodule
`default_nettype wire

// File: rtl/port_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : port_out_buffer
// Purpose  : Per-port output queue fed by the switch FSM, drained by the port.
//            Define PORT_BUSY_EARLY_EN to raise port_busy one entry early.
// Revision : 1.0
// ============================================================================
module port_out_buffer
  import switch_pkg::*;
#(
  parameter int W_WIDTH   = W_WIDTH_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int PORT_ADDR = PORT_ADDR_0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  port_out_buffer_if.slave bus
);

  localparam int PTR_W = clog2(DEPTH);

  logic               wr_hit;
  logic               wr_accept;
  logic               rd_accept;
  logic               full;
  logic               empty;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [W_WIDTH-1:0] mem_q [DEPTH];
  logic [W_WIDTH-1:0] mem_d [DEPTH];

  assign wr_hit = bus.wr_en && (bus.port_addr == W_WIDTH'(PORT_ADDR));

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_hit),
    .rd_req    (bus.port_read),
    .wr_accept (wr_accept),
    .rd_accept (rd_accept),
    .full      (full),
    .empty     (empty),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_accept) mem_d[wr_ptr] = bus.data_in;
  end

  // Storage is not reset; an empty queue masks its contents on port_data.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.port_ready = !empty;
  assign bus.port_data  = empty ? '0 : mem_q[rd_ptr];

`ifdef PORT_BUSY_EARLY_EN
  // Pointer distance equals DEPTH-1 exactly when one slot is left.
  logic [PTR_W-1:0] fill_mod;
  assign fill_mod      = wr_ptr - rd_ptr;
  assign bus.port_busy = full || (fill_mod == PTR_W'(DEPTH - 1));
`else
  assign bus.port_busy = full;
`endif

endmodule
`default_nettype wire

// File: tb/tb_port_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_out_buffer
// Purpose  : Self-checking bench for port_out_buffer (PORT_ADDR=2, DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_port_out_buffer;

  localparam int         DEPTH   = 4;
  localparam logic [7:0] MY_ADDR = 8'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  port_out_buffer_if #(.W_WIDTH(8)) bus_if ();

  port_out_buffer #(
    .W_WIDTH   (8),
    .DEPTH     (DEPTH),
    .PORT_ADDR (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference queue: contents the port should hold, head at index 0.
  logic [7:0] ref_q [$];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic       rd;
    int         exp_cnt;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  function automatic logic exp_busy(input int cnt);
`ifdef PORT_BUSY_EARLY_EN
    return cnt >= DEPTH - 1;
`else
    return cnt == DEPTH;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic we, input logic [7:0] addr, input logic [7:0] din,
                       input logic rd);
    bit wok, rok;
    bus_if.wr_en     = we;
    bus_if.port_addr = addr;
    bus_if.data_in   = din;
    bus_if.port_read = rd;
    @(posedge clk);
    wok = we && (addr == MY_ADDR) && (ref_q.size() < DEPTH);
    rok = rd && (ref_q.size() > 0);
    if (rok) void'(ref_q.pop_front());
    if (wok) ref_q.push_back(din);
    #1;
    bus_if.wr_en     = 1'b0;
    bus_if.port_read = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = ref_q.size();
    chk({tag, ".ready"}, 32'(bus_if.port_ready), 32'(n != 0));
    chk({tag, ".busy"},  32'(bus_if.port_busy),  32'(exp_busy(n)));
    chk({tag, ".data"},  32'(bus_if.port_data),  (n != 0) ? 32'(ref_q[0]) : 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ref_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic       r_we, r_rd;
  logic [7:0] r_a, r_d;
  int         phase;

  initial begin
    bus_if.wr_en     = 1'b0;
    bus_if.port_addr = 8'h00;
    bus_if.data_in   = 8'h00;
    bus_if.port_read = 1'b0;

    // Address filter, then fill / overflow / drain.
    vecs[0]  = '{1'b1, 8'h02, 8'hA5, 1'b0, 1, 8'hA5};
    vecs[1]  = '{1'b1, 8'h03, 8'h5A, 1'b0, 1, 8'hA5};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1, 8'hA5};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 0, 8'h00};
    vecs[5]  = '{1'b1, 8'h02, 8'h11, 1'b0, 1, 8'h11};
    vecs[6]  = '{1'b1, 8'h02, 8'h22, 1'b0, 2, 8'h11};
    vecs[7]  = '{1'b1, 8'h02, 8'h33, 1'b0, 3, 8'h11};
    vecs[8]  = '{1'b1, 8'h02, 8'h44, 1'b0, 4, 8'h11};
    vecs[9]  = '{1'b1, 8'h02, 8'h55, 1'b0, 4, 8'h11};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 3, 8'h22};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 2, 8'h33};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 1, 8'h44};
    vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 0, 8'h00};

    do_reset();
    chk("reset.ready", 32'(bus_if.port_ready), 32'd0);
    chk("reset.busy",  32'(bus_if.port_busy),  32'd0);
    chk("reset.data",  32'(bus_if.port_data),  32'd0);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].rd);
      chk($sformatf("vec%0d.ready", i), 32'(bus_if.port_ready), 32'(vecs[i].exp_cnt != 0));
      chk($sformatf("vec%0d.busy", i),  32'(bus_if.port_busy),  32'(exp_busy(vecs[i].exp_cnt)));
      chk($sformatf("vec%0d.data", i),  32'(bus_if.port_data),  32'(vecs[i].exp_data));
    end

    // Full + write + read: only the read is accepted.
    for (int i = 1; i <= 4; i++) cycle(1'b1, MY_ADDR, 8'(i * 'h11), 1'b0);
    chk("full.busy", 32'(bus_if.port_busy), 32'd1);
    chk("full.head", 32'(bus_if.port_data), 32'h11);
    cycle(1'b1, MY_ADDR, 8'h99, 1'b1);
    chk("fwr.ready", 32'(bus_if.port_ready), 32'd1);
    chk("fwr.busy",  32'(bus_if.port_busy),  32'(exp_busy(3)));
    chk("fwr.data",  32'(bus_if.port_data),  32'h22);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("fwr.data2", 32'(bus_if.port_data), 32'h33);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("fwr.data3", 32'(bus_if.port_data), 32'h44);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("fwr.drained", 32'(bus_if.port_ready), 32'd0);

    // Empty + write + read, then pointer wrap with one entry in flight.
    cycle(1'b1, MY_ADDR, 8'd0, 1'b1);
    chk("wrap0.ready", 32'(bus_if.port_ready), 32'd1);
    chk("wrap0.data",  32'(bus_if.port_data),  32'd0);
    for (int i = 1; i < 10; i++) begin
      cycle(1'b1, MY_ADDR, 8'(i), 1'b1);
      chk($sformatf("wrap%0d.ready", i), 32'(bus_if.port_ready), 32'd1);
      chk($sformatf("wrap%0d.busy", i),  32'(bus_if.port_busy),  32'(exp_busy(1)));
      chk($sformatf("wrap%0d.data", i),  32'(bus_if.port_data),  32'(i));
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("wrap.drained", 32'(bus_if.port_ready), 32'd0);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, MY_ADDR, 8'(8'hC0 + i), 1'b0);
    chk("prerst.ready", 32'(bus_if.port_ready), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.ready", 32'(bus_if.port_ready), 32'd0);
    chk("arst.busy",  32'(bus_if.port_busy),  32'd0);
    chk("arst.data",  32'(bus_if.port_data),  32'd0);
    ref_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, MY_ADDR, 8'h77, 1'b0);
    chk("postrst.ready", 32'(bus_if.port_ready), 32'd1);
    chk("postrst.data",  32'(bus_if.port_data),  32'h77);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("postrst.empty", 32'(bus_if.port_ready), 32'd0);

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 600; i++) begin
      phase = (i / 40) % 2;
      r_we  = $urandom_range(0, 99) < ((phase != 0) ? 30 : 80);
      r_rd  = $urandom_range(0, 99) < ((phase != 0) ? 80 : 30);
      r_a   = ($urandom_range(0, 3) != 0) ? MY_ADDR : 8'($urandom_range(0, 255));
      r_d   = 8'($urandom);
      cycle(r_we, r_a, r_d, r_rd);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
